// File: rtl/led_pulse_stretch.sv
`default_nettype none
// ============================================================================
//  Module   : led_pulse_stretch
//  Purpose  : Stretches short event strobes into visible LED blinks, queuing
//             events that arrive mid-blink in a saturating counter.
//  Revision : 1.0  initial release
// ============================================================================
module led_pulse_stretch #(
    parameter int ON_CYCLES  = 32,
    parameter int GAP_CYCLES = 16,
    parameter int CW         = 8,
    parameter int QW         = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          event_in,
    input  logic          clear,
    output logic          led_out,
    output logic          busy,
    output logic [QW-1:0] pending,
    output logic          overflow
);

    localparam logic [1:0]    S_IDLE   = 2'd0;
    localparam logic [1:0]    S_ON     = 2'd1;
    localparam logic [1:0]    S_GAP    = 2'd2;
    localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);
    localparam logic [QW-1:0] PEND_MAX = '1;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [QW-1:0] pend_q, pend_d;
    logic          ovf_q, ovf_d;
    logic          s1_q, s2_q, prev_q;
    logic          rise;
    logic          enq;

    assign rise = s2_q & ~prev_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        ovf_d   = ovf_q;
        enq     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d = S_ON;
                    cnt_d   = ON_LOAD;
                end
            end
            S_ON: begin
                enq = rise;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LOAD;
                end
            end
            S_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                    enq   = rise;
                end else if (pend_q != '0) begin
                    // A rise on the dequeue cycle replaces the dequeued entry
                    state_d = S_ON;
                    cnt_d   = ON_LOAD;
                    if (!rise) begin
                        pend_d = pend_q - 1'b1;
                    end
                end else if (rise && !clear) begin
                    state_d = S_ON;
                    cnt_d   = ON_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (enq) begin
            if (pend_q != PEND_MAX) begin
                pend_d = pend_q + 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end

        // Clear wins over every queue update, but leaves the period running
        if (clear) begin
            pend_d = '0;
            ovf_d  = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            s1_q    <= event_in;
            s2_q    <= s1_q;
            prev_q  <= s2_q;
        end
    end

    assign led_out  = (state_q == S_ON);
    assign busy     = (state_q != S_IDLE);
    assign pending  = pend_q;
    assign overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_led_pulse_stretch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_pulse_stretch
//  Purpose  : Scoreboard bench for led_pulse_stretch with a blink-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_led_pulse_stretch;

    localparam int ON   = 4;
    localparam int GAP  = 2;
    localparam int QW   = 2;
    localparam int PMAX = 3;

    logic          clock    = 1'b0;
    logic          reset    = 1'b0;
    logic          event_in = 1'b0;
    logic          clear    = 1'b0;
    logic          led_out;
    logic          busy;
    logic [QW-1:0] pending;
    logic          overflow;

    led_pulse_stretch #(
        .ON_CYCLES (ON),
        .GAP_CYCLES(GAP),
        .CW        (8),
        .QW        (QW)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .event_in(event_in),
        .clear   (clear),
        .led_out (led_out),
        .busy    (busy),
        .pending (pending),
        .overflow(overflow)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic          led;
        logic          busy;
        logic [QW-1:0] pend;
        logic          ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks   = 0;
    int   n_fail     = 0;

    // Reference model: remaining lit clocks, remaining dark clocks, queue size
    int   on_left    = 0;
    int   gap_left   = 0;
    int   m_pend     = 0;
    bit   m_ovf      = 1'b0;
    bit   e1 = 1'b0, e2 = 1'b0, e3 = 1'b0;
    int   m_blinks   = 0;
    int   dut_blinks = 0;
    bit   led_prev   = 1'b0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        on_left  = 0;
        gap_left = 0;
        m_pend   = 0;
        m_ovf    = 1'b0;
        e1 = 1'b0; e2 = 1'b0; e3 = 1'b0;
    endtask

    task automatic start_blink();
        on_left = ON;
        m_blinks++;
    endtask

    task automatic model_step(input bit ev, input bit clr);
        bit rise;
        bit r;
        bit enq;
        rise = e2 & ~e3;
        r    = rise & ~clr;
        enq  = 1'b0;
        if (on_left > 0) begin
            on_left--;
            enq = r;
            if (on_left == 0) gap_left = GAP;
        end else if (gap_left > 1) begin
            gap_left--;
            enq = r;
        end else if (gap_left == 1) begin
            gap_left = 0;
            if (m_pend > 0) begin
                start_blink();
                if (!r) m_pend--;
            end else if (r) begin
                start_blink();
            end
        end else if (rise) begin
            start_blink();
        end
        if (enq) begin
            if (m_pend < PMAX) m_pend++;
            else m_ovf = 1'b1;
        end
        if (clr) begin
            m_pend = 0;
            m_ovf  = 1'b0;
        end
        e3 = e2; e2 = e1; e1 = ev;
    endtask

    // One clock: drive inputs at the falling edge and predict the next edge
    task automatic cyc(input bit ev, input bit clr, input bit rn = 1'b1);
        exp_t e;
        @(negedge clock);
        reset    = rn;
        event_in = ev;
        clear    = clr;
        if (!rn) model_reset();
        else     model_step(ev, clr);
        e.led  = (on_left > 0);
        e.busy = (on_left > 0) || (gap_left > 0);
        e.pend = QW'(m_pend);
        e.ovf  = m_ovf;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("led_out",  int'(led_out),  int'(e.led));
                check("busy",     int'(busy),     int'(e.busy));
                check("pending",  int'(pending),  int'(e.pend));
                check("overflow", int'(overflow), int'(e.ovf));
                if (led_out && !led_prev) dut_blinks++;
                led_prev = led_out;
            end
        end
    end

    initial begin
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        idle(2);

        // single pulse
        cyc(1'b1, 1'b0);
        idle(12);

        // three pulses one clock apart
        cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); cyc(1'b1, 1'b0);
        idle(30);

        // saturate the queue, then clear the sticky overflow
        repeat (6) begin
            cyc(1'b1, 1'b0);
            cyc(1'b0, 1'b0);
        end
        idle(40);
        cyc(1'b0, 1'b1);
        idle(3);

        // rise lands on the last gap clock
        cyc(1'b1, 1'b0);
        idle(5);
        cyc(1'b1, 1'b0);
        idle(20);

        // clear during a blink with two queued
        repeat (4) begin
            cyc(1'b1, 1'b0);
            cyc(1'b0, 1'b0);
        end
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        idle(20);

        // asynchronous reset in the middle of a lit period
        cyc(1'b1, 1'b0);
        idle(3);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("async_led",  int'(led_out),  0);
        check("async_busy", int'(busy),     0);
        check("async_pend", int'(pending),  0);
        check("async_ovf",  int'(overflow), 0);
        model_reset();
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        idle(15);

        // random traffic with occasional clears
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 49) == 0));
        end
        idle(60);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
        @(posedge clock);
        #3;
        check("queue_drained", exp_q.size(), 0);
        check("blink_count", dut_blinks, m_blinks);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
